// File: rtl/bus_fabric_pkg.sv
// Shared types and constants for the bus fabric: FSM states, the default
// wait-counter width and the default three-slave CPU address map.
package bus_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEFAULT_TIMEOUT = 15;
  localparam int CNT_W = $clog2(DEFAULT_TIMEOUT + 1);

  // CPU system map: slave 0 = IO, slave 1 = RAM, slave 2 = peripherals.
  localparam int CPU_NS     = 3;
  localparam int CPU_IO     = 0;
  localparam int CPU_RAM    = 1;
  localparam int CPU_PERIPH = 2;
  localparam logic [CPU_NS*16-1:0] CPU_BASE = {16'h8000, 16'h4000, 16'h0000};
  localparam logic [CPU_NS*16-1:0] CPU_MASK = {16'hF000, 16'hC000, 16'hC000};

endpackage

// File: rtl/bus_fabric_decoder.sv
// Combinational address-window decoder. Slave i hits when
// (addr & mask_i) == base_i; with overlapping windows the lowest index wins,
// so hit_vec is always zero or one-hot.
module addr_window_decoder
  import bus_fabric_pkg::*;
#(
  parameter int AW = 16,
  parameter int NS = 4
) (
  input  logic [AW-1:0]    addr,
  input  logic [NS*AW-1:0] base,
  input  logic [NS*AW-1:0] mask,
  output logic [NS-1:0]    hit_vec,
  output logic             hit
);

  // Priority scan from slave 0 upward; the first matching window claims the access.
  always_comb begin
    hit_vec = '0;
    hit     = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (!hit && ((addr & mask[i*AW +: AW]) == base[i*AW +: AW])) begin
        hit_vec[i] = 1'b1;
        hit        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Single-outstanding memory-mapped interconnect from the CPU data port to NS
// slaves. Requests are decoded against programmable windows, forwarded with
// registered chip-selects, and completed by a one-cycle m_ready pulse. A miss
// or an ack that does not arrive within TIMEOUT access cycles completes with
// m_err set and zero read data.
//
// Handshake: the master raises m_req with address/data stable; the request is
// taken on the rising edge on which the fabric is IDLE. Completion is the
// single cycle in which m_ready = 1; m_err and m_rdata are meaningful then,
// and m_rdata holds until the next completion. Toward the slaves, s_cs[i]
// stays high with stable s_addr/s_write/s_wdata until s_ack[i] is seen on a
// rising edge; acks from unselected slaves are ignored.
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int NS = 4,
  parameter logic [NS*AW-1:0] BASE = {NS{16'h0000}},
  parameter logic [NS*AW-1:0] MASK = {NS{16'hC000}},
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_req,
  input  logic [AW-1:0]    m_addr,
  input  logic             m_write,
  input  logic [DW-1:0]    m_wdata,
  output logic [DW-1:0]    m_rdata,
  output logic             m_ready,
  output logic             m_err,
  output logic [NS-1:0]    s_cs,
  output logic             s_write,
  output logic [AW-1:0]    s_addr,
  output logic [DW-1:0]    s_wdata,
  input  logic [NS*DW-1:0] s_rdata,
  input  logic [NS-1:0]    s_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state;
  state_t          state_next;
  logic [NS-1:0]   hit_vec;
  logic            hit;
  logic [CW-1:0]   cnt;
  logic            ack_sel;
  logic [DW-1:0]   rdata_sel;
  logic            timeout;

  addr_window_decoder #(
    .AW (AW),
    .NS (NS)
  ) u_decoder (
    .addr    (m_addr),
    .base    (BASE),
    .mask    (MASK),
    .hit_vec (hit_vec),
    .hit     (hit)
  );

  // s_cs is one-hot during ACCESS, so it directly selects the ack and read slice.
  always_comb begin
    ack_sel   = |(s_ack & s_cs);
    rdata_sel = '0;
    for (int i = 0; i < NS; i++) begin
      if (s_cs[i]) rdata_sel = s_rdata[i*DW +: DW];
    end
  end

  // Last permitted access cycle; an ack arriving in it still wins.
  assign timeout = (cnt == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (m_req) state_next = hit ? ACCESS : ERR;
      ACCESS:  if (ack_sel || timeout) state_next = DONE;
      ERR:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered slave-side and master-side outputs plus the wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_rdata <= '0;
      m_ready <= 1'b0;
      m_err   <= 1'b0;
      s_cs    <= '0;
      s_write <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      cnt     <= '0;
    end else begin
      m_ready <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (m_req && hit) begin
            s_cs    <= hit_vec;
            s_write <= m_write;
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            cnt     <= '0;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (ack_sel) begin
            s_cs    <= '0;
            s_write <= 1'b0;
            m_err   <= 1'b0;
            m_rdata <= s_write ? '0 : rdata_sel;
          end else if (timeout) begin
            s_cs    <= '0;
            s_write <= 1'b0;
            m_err   <= 1'b1;
            m_rdata <= '0;
          end
        end
        ERR: begin
          m_err   <= 1'b1;
          m_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
